// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with post-reset clear sweep
// Two write ports (port 1 wins on collision), NREAD combinational read ports, optional x0 and bypass.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    WE0,
  input  logic [ADDR_W-1:0]       WADDR0,
  input  logic [XLEN-1:0]         WDATA0,
  input  logic                    WE1,
  input  logic [ADDR_W-1:0]       WADDR1,
  input  logic [XLEN-1:0]         WDATA1,
  input  logic [NREAD*ADDR_W-1:0] RADDR,
  output logic [NREAD*XLEN-1:0]   RDATA,
  output logic                    BUSY,
  output logic                    WDROP
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [XLEN-1:0]   mem [NREGS];
  logic              wen0;
  logic              wen1;

  // Writes aimed at the hardwired zero register are filtered once and reused by the bypass.
  assign wen0 = WE0 && !((ZERO_REG != 0) && (WADDR0 == '0));
  assign wen1 = WE1 && !((ZERO_REG != 0) && (WADDR1 == '0));
  assign BUSY = (state == CLEAR);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= CLEAR;
      ptr   <= '0;
      WDROP <= 1'b0;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
      ptr      <= ptr + ADDR_W'(1);
      if (ptr == ADDR_W'(NREGS - 1))
        state <= READY;
      WDROP <= WE0 | WE1;
    end else begin
      WDROP <= 1'b0;
      if (wen0 && !(wen1 && (WADDR1 == WADDR0)))
        mem[WADDR0] <= WDATA0;
      if (wen1)
        mem[WADDR1] <= WDATA1;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [XLEN-1:0]   rd;

    assign ra = RADDR[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[ra];
      if (BUSY)
        rd = '0;
      else if ((ZERO_REG != 0) && (ra == '0))
        rd = '0;
      else if ((BYPASS != 0) && wen1 && (WADDR1 == ra))
        rd = WDATA1;
      else if ((BYPASS != 0) && wen0 && (WADDR0 == ra))
        rd = WDATA0;
    end

    assign RDATA[k*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (bypass, no-bypass and 4x64 instances)
module tb_regfile_mp;

  localparam int A0 = 0, A1 = 1, B0 = 2, B1 = 3, C0 = 4;
  localparam int ABUSY = 8, AWDROP = 9, BBUSY = 10, CBUSY = 11, BWDROP = 12;

  typedef struct {
    string       tag;
    int          src;
    logic [63:0] exp;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        we0 = 0, we1 = 0;
  logic [4:0]  waddr0 = 0, waddr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic [9:0]  raddr = 0;
  logic [63:0] a_rdata, b_rdata;
  logic        a_busy, a_wdrop, b_busy, b_wdrop;

  logic        c_we0 = 0, c_we1 = 0;
  logic [4:0]  c_waddr0 = 0, c_waddr1 = 0;
  logic [63:0] c_wdata0 = 0, c_wdata1 = 0;
  logic [19:0] c_raddr = 0;
  logic [255:0] c_rdata;
  logic        c_busy, c_wdrop;

  exp_t        sbq[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 CLK = ~CLK;

  regfile_mp u_a (
    .CLK(CLK), .RESET(RESET), .WE0(we0), .WADDR0(waddr0), .WDATA0(wdata0),
    .WE1(we1), .WADDR1(waddr1), .WDATA1(wdata1), .RADDR(raddr),
    .RDATA(a_rdata), .BUSY(a_busy), .WDROP(a_wdrop));

  regfile_mp #(.BYPASS(0)) u_b (
    .CLK(CLK), .RESET(RESET), .WE0(we0), .WADDR0(waddr0), .WDATA0(wdata0),
    .WE1(we1), .WADDR1(waddr1), .WDATA1(wdata1), .RADDR(raddr),
    .RDATA(b_rdata), .BUSY(b_busy), .WDROP(b_wdrop));

  regfile_mp #(.XLEN(64), .NREAD(4)) u_c (
    .CLK(CLK), .RESET(RESET), .WE0(c_we0), .WADDR0(c_waddr0), .WDATA0(c_wdata0),
    .WE1(c_we1), .WADDR1(c_waddr1), .WDATA1(c_wdata1), .RADDR(c_raddr),
    .RDATA(c_rdata), .BUSY(c_busy), .WDROP(c_wdrop));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] actual(input int src);
    case (src)
      A0:      return {32'h0, a_rdata[31:0]};
      A1:      return {32'h0, a_rdata[63:32]};
      B0:      return {32'h0, b_rdata[31:0]};
      B1:      return {32'h0, b_rdata[63:32]};
      4, 5, 6, 7: return c_rdata[(src-4)*64 +: 64];
      ABUSY:   return {63'h0, a_busy};
      AWDROP:  return {63'h0, a_wdrop};
      BBUSY:   return {63'h0, b_busy};
      CBUSY:   return {63'h0, c_busy};
      BWDROP:  return {63'h0, b_wdrop};
      default: return 'x;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return model[a];
  endfunction

  task automatic push(input string tag, input int src, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.src = src; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    @(negedge CLK);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, actual(e.src), e.exp);
    end
  endtask

  task automatic drive(input logic w0, input logic [4:0] ad0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] ad1, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1);
    @(posedge CLK); #1;
    we0 = w0; waddr0 = ad0; wdata0 = d0;
    we1 = w1; waddr1 = ad1; wdata1 = d1;
    raddr = {r1, r0};
    c_we0 = 0; c_we1 = 0;
  endtask

  task automatic finish_cycle();
    drain();
    if (we0 && waddr0 != 0) model[waddr0] = wdata0;
    if (we1 && waddr1 != 0) model[waddr1] = wdata1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 1; i <= 32; i++) begin
      @(posedge CLK); #1;
      push({tag, "_busy_a"}, ABUSY, (i < 32));
      push({tag, "_busy_b"}, BBUSY, (i < 32));
      push({tag, "_busy_c"}, CBUSY, (i < 32));
      drain();
    end
    foreach (model[j]) model[j] = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (model[j]) model[j] = 32'h0;
    raddr = {5'd3, 5'd0};
    repeat (3) @(posedge CLK);
    #1;
    push("rst_busy", ABUSY, 1);
    push("rst_wdrop", AWDROP, 0);
    push("rst_rd0", A0, 0);
    push("rst_rd1", A1, 0);
    push("rst_c_busy", CBUSY, 1);
    drain();
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Sweep with a write injected so it lands on the 10th sweep edge.
    for (int i = 1; i <= 32; i++) begin
      @(posedge CLK); #1;
      we0 = (i == 9); waddr0 = 5'd3; wdata0 = 32'hCAFE_0003;
      push("sweep_busy", ABUSY, (i < 32));
      push("sweep_busy_b", BBUSY, (i < 32));
      push("sweep_busy_c", CBUSY, (i < 32));
      push("sweep_wdrop", AWDROP, (i == 10));
      push("sweep_wdrop_b", BWDROP, (i == 10));
      push("sweep_rd", A1, 0);
      drain();
    end

    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      c_raddr = {4{5'(a)}};
      push("clr_a0", A0, 0);
      push("clr_a1", A1, 0);
      push("clr_b0", B0, 0);
      push("clr_c0", C0, 0);
      finish_cycle();
    end

    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 0);
    push("wr5_byp", A0, 32'hDEAD_BEEF);
    push("wr5_nobyp", B0, 0);
    push("wr5_p1", A1, 0);
    push("wr5_wdrop", AWDROP, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    push("rd5_a", A0, 32'hDEAD_BEEF);
    push("rd5_b", B0, 32'hDEAD_BEEF);
    push("rd0_a", A1, 0);
    finish_cycle();

    drive(1, 7, 32'h11, 1, 7, 32'h22, 7, 0);
    push("conf_byp", A0, 32'h22);
    push("conf_nobyp", B0, 0);
    finish_cycle();
    drive(0, 0, 0, 1, 0, 32'hFFFF, 7, 0);
    push("conf_a", A0, 32'h22);
    push("conf_b", B0, 32'h22);
    push("x0_byp", A1, 0);
    push("x0_nobyp", B1, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    push("x0_a", A0, 0);
    push("x0_b", B0, 0);
    push("conf_a1", A1, 32'h22);
    finish_cycle();

    drive(1, 9, 32'hA5A5, 0, 0, 0, 0, 9);
    push("byp9_a", A1, 32'hA5A5);
    push("byp9_b", B1, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 9);
    push("after9_a", A1, 32'hA5A5);
    push("after9_b", B1, 32'hA5A5);
    finish_cycle();

    for (int n = 0; n < 60; n++) begin
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      push("rnd_a0", A0, model_rd(raddr[4:0], 1));
      push("rnd_a1", A1, model_rd(raddr[9:5], 1));
      push("rnd_b0", B0, model_rd(raddr[4:0], 0));
      push("rnd_b1", B1, model_rd(raddr[9:5], 0));
      finish_cycle();
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    c_we0 = 1; c_waddr0 = 1; c_wdata0 = 64'h1111_2222_3333_4444;
    c_we1 = 1; c_waddr1 = 2; c_wdata1 = 64'hAAAA_BBBB_CCCC_DDDD;
    drain();
    @(posedge CLK); #1;
    c_we0 = 1; c_waddr0 = 3; c_wdata0 = 64'h0123_4567_89AB_CDEF;
    c_we1 = 1; c_waddr1 = 4; c_wdata1 = 64'hFEDC_BA98_7654_3210;
    c_raddr = {5'd1, 5'd2, 5'd3, 5'd4};
    push("c_byp_l0", C0, 64'hFEDC_BA98_7654_3210);
    push("c_byp_l1", C0 + 1, 64'h0123_4567_89AB_CDEF);
    push("c_l2", C0 + 2, 64'hAAAA_BBBB_CCCC_DDDD);
    push("c_l3", C0 + 3, 64'h1111_2222_3333_4444);
    drain();
    @(posedge CLK); #1;
    c_we0 = 0; c_we1 = 0;
    c_raddr = {5'd4, 5'd3, 5'd2, 5'd1};
    push("c_rd_l0", C0, 64'h1111_2222_3333_4444);
    push("c_rd_l1", C0 + 1, 64'hAAAA_BBBB_CCCC_DDDD);
    push("c_rd_l2", C0 + 2, 64'h0123_4567_89AB_CDEF);
    push("c_rd_l3", C0 + 3, 64'hFEDC_BA98_7654_3210);
    drain();

    drive(1, 30, 32'h1234, 0, 0, 0, 30, 5);
    finish_cycle();
    drive(0, 0, 0, 0, 0, 0, 30, 5);
    push("pre_rst30", A0, 32'h1234);
    finish_cycle();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      push("mid_busy", ABUSY, 1);
      drain();
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    push("mid_rst_busy", ABUSY, 1);
    drain();
    RESET = 1'b0;
    sweep("resweep");
    drive(0, 0, 0, 0, 0, 0, 30, 5);
    push("clr30", A0, 0);
    push("clr5", A1, 0);
    push("clr30_b", B0, 0);
    finish_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
